// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/response bundle between the core pipeline and muldiv_seq
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_operand_a;
    logic [XLEN-1:0] i_operand_b;
    logic            i_kill;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;
    logic            o_busy;

    modport master (
        output i_valid, i_op, i_operand_a, i_operand_b, i_kill, i_ready,
        input  o_ready, o_valid, o_result, o_busy
    );

    modport slave (
        input  i_valid, i_op, i_operand_a, i_operand_b, i_kill, i_ready,
        output o_ready, o_valid, o_result, o_busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV32M multiply/divide unit with valid/ready handshake
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic           i_clk,
    input  logic           i_reset,
    muldiv_seq_if.slave    bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST_IT  = {CW{1'b1}};

    logic [1:0]      state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;      // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] rem_q;
    logic [CW-1:0]   cnt;
    logic            neg_quo;
    logic            neg_rem;
    logic            valid_q;
    logic [XLEN-1:0] result_q;

    logic                    accept;
    logic                    op_is_div;
    logic                    op_signed_div;
    logic [XLEN-1:0]         a_mag;
    logic [XLEN-1:0]         b_mag;
    logic [XLEN:0]           rem_shift;
    logic [XLEN:0]           diff;
    logic [XLEN-1:0]         q_step;
    logic [XLEN-1:0]         r_step;
    logic [XLEN-1:0]         q_final;
    logic [XLEN-1:0]         r_final;
    logic signed [XLEN:0]    mul_a;
    logic signed [XLEN:0]    mul_b;
    logic signed [2*XLEN+1:0] product;

    assign accept        = bus.i_valid && (state == ST_IDLE) && !bus.i_kill;
    assign op_is_div     = bus.i_op[2];
    assign op_signed_div = bus.i_op[2] && !bus.i_op[0];

    assign bus.o_ready  = (state == ST_IDLE);
    assign bus.o_busy   = (state != ST_IDLE);
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;

    always_comb begin
        a_mag = (op_signed_div && bus.i_operand_a[XLEN-1]) ? (~bus.i_operand_a + 1'b1) : bus.i_operand_a;
        b_mag = (op_signed_div && bus.i_operand_b[XLEN-1]) ? (~bus.i_operand_b + 1'b1) : bus.i_operand_b;

        // Remainder stays below the divisor, so the shifted value fits in XLEN+1 bits.
        rem_shift = {rem_q, a_q[XLEN-1]};
        diff      = rem_shift - {1'b0, b_q};
        q_step    = {a_q[XLEN-2:0], ~diff[XLEN]};
        r_step    = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
        q_final   = neg_quo ? (~q_step + 1'b1) : q_step;
        r_final   = neg_rem ? (~r_step + 1'b1) : r_step;

        // MULHU zero-extends a; only MUL/MULH sign-extend b.
        mul_a   = {(op_q != 3'b011) && a_q[XLEN-1], a_q};
        mul_b   = {!op_q[1] && b_q[XLEN-1], b_q};
        product = mul_a * mul_b;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            cnt      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (bus.i_kill) begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.i_op;
                        rem_q   <= '0;
                        cnt     <= '0;
                        neg_quo <= op_signed_div && (bus.i_operand_a[XLEN-1] ^ bus.i_operand_b[XLEN-1]);
                        neg_rem <= op_signed_div && bus.i_operand_a[XLEN-1];
                        if (!op_is_div) begin
                            a_q   <= bus.i_operand_a;
                            b_q   <= bus.i_operand_b;
                            state <= ST_MUL;
                        end else if (bus.i_operand_b == '0) begin
                            a_q      <= bus.i_operand_a;
                            b_q      <= bus.i_operand_b;
                            result_q <= bus.i_op[1] ? bus.i_operand_a : {XLEN{1'b1}};
                            valid_q  <= 1'b1;
                            state    <= ST_DONE;
                        end else if (op_signed_div && (bus.i_operand_a == MOST_NEG) &&
                                     (bus.i_operand_b == {XLEN{1'b1}})) begin
                            a_q      <= bus.i_operand_a;
                            b_q      <= bus.i_operand_b;
                            result_q <= bus.i_op[1] ? '0 : MOST_NEG;
                            valid_q  <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            a_q   <= a_mag;
                            b_q   <= b_mag;
                            state <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    result_q <= (op_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
                    valid_q  <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DIV: begin
                    a_q   <= q_step;
                    rem_q <= r_step;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_IT) begin
                        result_q <= op_q[1] ? r_final : q_final;
                        valid_q  <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                default: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle M-extension execution unit that a pipelined core stalls on.
- Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request through a valid/ready handshake and sequences it:
  - a registered 1-iteration multiply, or
  - a 32-iteration restoring shift-subtract divide.
- Holds the result until the consumer accepts it.
- Sits beside the single-cycle ALU; the decoder routes funct7=0000001 ops here.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- i_clk  in  1  clock, rising-edge.
- i_reset  in  1  asynchronous active-low reset.
- i_valid  in  1  request present.
- o_ready  out  1  unit can accept a request; high only in IDLE.
- i_op  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_operand_a  in  XLEN  rs1 value.
- i_operand_b  in  XLEN  rs2 value.
- i_kill  in  1  pipeline flush; aborts any operation.
- o_valid  out  1  o_result is valid.
- i_ready  in  1  consumer takes the result.
- o_result  out  XLEN  result.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (i_reset low, asynchronous):
  - state=IDLE, o_valid=0, o_result=0, internal quotient/remainder/operand registers=0.
  - o_ready=1 and o_busy=0 (both combinational from state).
- States are IDLE, MUL, DIV and DONE.
- Accept happens when i_valid & o_ready & ~i_kill at a rising edge. At accept:
  - latch op, a and b;
  - MUL ops go to MUL;
  - DIV/DIVU/REM/REMU with b==0 go directly to DONE with the result loaded: quotient all-ones, remainder = a;
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF go directly to DONE: quotient 0x80000000, remainder 0;
  - all other divides go to DIV with iteration counter 0.
- MUL state, one cycle:
  - 64-bit product of sign-extended/zero-extended operands:
    - MUL and MULH: both operands signed;
    - MULHSU: a signed, b unsigned;
    - MULHU: both operands unsigned.
  - MUL returns bits [31:0]; the others return bits [63:32].
  - Result is registered into o_result; next state is DONE.
- DIV state:
  - Operands are converted to magnitudes at accept; signed ops only; the sign of each result is recorded.
  - Each cycle performs one restoring step: remainder shift-in of the dividend MSB, trial subtract, quotient bit set if non-negative.
  - After the 32nd step:
    - quotient is negated if signs differed (DIV);
    - remainder takes the dividend sign (REM);
    - the selected result is registered into o_result; next state is DONE.
  - The 5-bit counter wraps from 31 to 0 only on exit.
- Latency, with the accept cycle as cycle 0, o_valid first high in:
  - cycle 2 for MUL ops;
  - cycle 33 for normal divides;
  - cycle 1 for the divide-by-zero and overflow special cases.
- DONE:
  - o_valid=1 and o_result stable.
  - On i_ready go to IDLE, with o_valid=0 the next cycle.
  - No accept while in DONE; back-to-back issue costs one IDLE cycle.
- i_kill:
  - From any state, the next edge goes to IDLE with o_valid=0.
  - o_result keeps its old value but is not valid.
  - Kill has priority over accept and over i_ready in the same cycle.
- In IDLE, inputs other than i_valid/i_kill are ignored; i_ready outside DONE is ignored.
- Reset asserted mid-operation: immediate return to reset values; no partial result is ever presented.

Test Plan:
- MULH 0xFFFFFFFF × 0xFFFFFFFF (-1×-1) -> o_valid in cycle 2, o_result=0x00000000; repeat with MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF; MUL -> 0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> o_valid at cycle 33, o_result=0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> o_valid cycle 1, 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_result stable, o_ready=0; raise i_ready -> IDLE next cycle, o_ready=1.
- Kill at DIV iteration 10, with i_valid high in the same cycle -> IDLE next edge, o_valid never asserted, no new accept; a following DIVU 9/3 returns 3 at cycle 33.
- Drop i_reset asynchronously (no clock edge) mid-DIV -> o_valid=0, o_busy=0, o_result=0 immediately; after release, MUL 3×4 -> 12 at cycle 2.
